// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 mux into a one-entry output register.
// Latency: one cycle from the accepting edge to out_msg/out_val.
// Backpressure: both in*_rdy drop while out_val=1 and out_rdy=0; a same-cycle drain and refill is allowed.
module mux2_arbiter #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_val,
    output logic               in0_rdy,
    input  logic [p_nbits-1:0] in0_msg,
    input  logic               in1_val,
    output logic               in1_rdy,
    input  logic [p_nbits-1:0] in1_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               sel,
    output logic [7:0]         grant_count
);

    logic               out_val_q;
    logic [p_nbits-1:0] out_msg_q;
    logic               prio_q;
    logic               sel_q;
    logic [7:0]         cnt_q;

    logic               can_accept;
    logic               grant0;
    logic               grant1;
    logic               any_grant;
    logic [p_nbits-1:0] mux_msg;

    // Grants are gated by reset so neither rdy can rise while reset is held low.
    always_comb begin
        can_accept = !out_val_q || out_rdy;
        grant0     = reset && can_accept && in0_val && (!in1_val || !prio_q);
        grant1     = reset && can_accept && in1_val && (!in0_val || prio_q);
        any_grant  = grant0 || grant1;
        sel        = any_grant ? grant1 : sel_q;
        mux_msg    = sel ? in1_msg : in0_msg;
    end

    assign in0_rdy     = grant0;
    assign in1_rdy     = grant1;
    assign out_val     = out_val_q;
    assign out_msg     = out_msg_q;
    assign grant_count = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            prio_q    <= 1'b0;
            sel_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else if (any_grant) begin
            out_val_q <= 1'b1;
            out_msg_q <= mux_msg;
            prio_q    <= !grant1;
            sel_q     <= grant1;
            cnt_q     <= cnt_q + 8'd1;
        end else if (out_val_q && out_rdy) begin
            out_val_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed and random checks of mux2_arbiter against a cycle-level reference model and message scoreboard.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in0_val;
    logic       in1_val;
    logic       out_rdy;
    logic [7:0] in0_msg;
    logic [7:0] in1_msg;
    logic       in0_rdy;
    logic       in1_rdy;
    logic       out_val;
    logic [7:0] out_msg;
    logic       sel;
    logic [7:0] grant_count;

    int errors = 0;
    int checks = 0;

    logic       m_val;
    logic       m_prio;
    logic       m_sel;
    logic [7:0] m_cnt;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    mux2_arbiter #(.p_nbits(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in0_val    (in0_val),
        .in0_rdy    (in0_rdy),
        .in0_msg    (in0_msg),
        .in1_val    (in1_val),
        .in1_rdy    (in1_rdy),
        .in1_msg    (in1_msg),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .sel        (sel),
        .grant_count(grant_count)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at the next falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk1({tag, ".out_val"}, out_val, 1'b0);
        chk1({tag, ".in0_rdy"}, in0_rdy, 1'b0);
        chk1({tag, ".in1_rdy"}, in1_rdy, 1'b0);
        chk1({tag, ".sel"}, sel, 1'b0);
        chk8({tag, ".out_msg"}, out_msg, 8'h00);
        chk8({tag, ".grant_count"}, grant_count, 8'h00);
        @(negedge clk);
        chk1({tag, ".held_in0_rdy"}, in0_rdy, 1'b0);
        chk1({tag, ".held_out_val"}, out_val, 1'b0);
        m_val  = 1'b0;
        m_prio = 1'b0;
        m_sel  = 1'b0;
        m_cnt  = 8'd0;
        sb_q.delete();
        reset = 1'b1;
    endtask

    // One clock cycle: call just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        logic       can;
        logic       g0;
        logic       g1;
        logic       e_sel;
        logic [7:0] pushed;
        #1;
        can   = !m_val || out_rdy;
        g0    = can && in0_val && (!in1_val || !m_prio);
        g1    = can && in1_val && (!in0_val || m_prio);
        e_sel = (g0 || g1) ? g1 : m_sel;
        chk1({tag, ".in0_rdy"}, in0_rdy, g0);
        chk1({tag, ".in1_rdy"}, in1_rdy, g1);
        chk1({tag, ".sel"}, sel, e_sel);
        chk1({tag, ".out_val"}, out_val, m_val);
        if (m_val) begin
            chk1({tag, ".sb_nonempty"}, sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                chk8({tag, ".out_msg"}, out_msg, sb_q[0]);
                if (out_rdy) void'(sb_q.pop_front());
            end
        end
        pushed = g1 ? in1_msg : in0_msg;
        @(posedge clk);
        if (g0 || g1) begin
            sb_q.push_back(pushed);
            m_val  = 1'b1;
            m_prio = !g1;
            m_sel  = g1;
            m_cnt  = m_cnt + 8'd1;
        end else if (m_val && out_rdy) begin
            m_val = 1'b0;
        end
        @(negedge clk);
        chk8({tag, ".grant_count"}, grant_count, m_cnt);
    endtask

    initial begin
        reset   = 1'b0;
        in0_val = 1'b1;
        in1_val = 1'b1;
        in0_msg = 8'h01;
        in1_msg = 8'h02;
        out_rdy = 1'b1;
        m_val   = 1'b0;
        m_prio  = 1'b0;
        m_sel   = 1'b0;
        m_cnt   = 8'd0;

        // Reset held with both requesters valid; first grant afterwards goes to in0.
        @(negedge clk);
        do_reset("rst");
        cycle("rst_first");
        chk8("rst_first.msg", out_msg, 8'h01);

        // Single requester.
        do_reset("rst2");
        in0_val = 1'b1; in0_msg = 8'hA5; in1_val = 1'b0; out_rdy = 1'b1;
        cycle("single");
        chk8("single.out_msg", out_msg, 8'hA5);
        chk1("single.out_val", out_val, 1'b1);
        chk8("single.count", grant_count, 8'd1);

        // Round-robin with both requesters continuously valid.
        do_reset("rst3");
        in0_val = 1'b1; in0_msg = 8'h11; in1_val = 1'b1; in1_msg = 8'h22; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle("rr");
        in0_val = 1'b0; in1_val = 1'b0;
        cycle("rr_drain");

        // Backpressure, then same-cycle refill from the favoured requester.
        in0_val = 1'b1; in0_msg = 8'h33;
        cycle("bp_fill");
        out_rdy = 1'b0; in1_val = 1'b1; in0_msg = 8'h44; in1_msg = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk8("bp_hold.msg33", out_msg, 8'h33);
        end
        out_rdy = 1'b1;
        cycle("bp_refill");
        chk8("bp_refill.msg", out_msg, 8'h55);
        chk1("bp_refill.out_val", out_val, 1'b1);

        // Async reset mid-stream with prio pointing at in1 beforehand.
        in1_val = 1'b0; in0_msg = 8'h66;
        cycle("mid_fill");
        #2;
        chk1("mid.pre_out_val", out_val, 1'b1);
        do_reset("mid_rst");
        in0_val = 1'b1; in1_val = 1'b1; in0_msg = 8'h77; in1_msg = 8'h88;
        cycle("post_rst");
        chk8("post_rst.msg", out_msg, 8'h77);

        // Counter wrap after 256 transfers.
        do_reset("rst4");
        in0_val = 1'b1; in1_val = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in0_msg = 8'(i);
            cycle("wrap");
        end
        chk8("wrap.count", grant_count, 8'h00);

        // Random traffic, then drain and confirm nothing is lost or duplicated.
        for (int i = 0; i < 20; i++) begin
            in0_val = 1'($urandom_range(0, 1));
            in1_val = 1'($urandom_range(0, 1));
            in0_msg = 8'($urandom);
            in1_msg = 8'($urandom);
            out_rdy = 1'($urandom_range(0, 1));
            cycle("rand");
        end
        in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) cycle("drain");
        chk1("drain.sb_empty", sb_q.size() == 0, 1'b1);
        chk1("drain.out_val", out_val, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester round-robin arbiter that shares the 8-bit 2:1 mux datapath between two latency-insensitive producers and drives one registered output stream. It sits in front of the function-calculator operand path. It decides which input owns the mux select each cycle, performs the val/rdy handshakes on both sides, and buffers the selected message in a one-entry output register.

## Interface
- p_nbits, 8, message width; mux datapath width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- in0_val  input  1  requester 0 has a valid message
- in0_rdy  output  1  arbiter accepts in0_msg this cycle
- in0_msg  input  p_nbits  requester 0 message
- in1_val  input  1  requester 1 has a valid message
- in1_rdy  output  1  arbiter accepts in1_msg this cycle
- in1_msg  input  p_nbits  requester 1 message
- out_val  output  1  out_msg holds a valid message
- out_rdy  input  1  consumer accepts out_msg this cycle
- out_msg  output  p_nbits  registered, arbitrated message
- sel  output  1  current mux select (0 = in0, 1 = in1); valid only when a grant is issued
- grant_count  output  8  number of accepted input transfers, wraps 255 -> 0

## Operation
- Transfer on any port occurs when val & rdy are both 1 at a rising clk edge.
- Output register states:
  - EMPTY: out_val = 0.
  - FULL: out_val = 1.
- can_accept = !out_val | out_rdy. This allows a pass-through refill in the same cycle the output drains.
- Priority pointer prio (1 bit): 0 means in0 is favoured, 1 means in1 is favoured.
- Grant logic (combinational, only when can_accept):
  - Only in0_val: grant in0.
  - Only in1_val: grant in1.
  - Both valid: grant the requester selected by prio.
  - Neither valid: no grant.
- in0_rdy = can_accept & grant0; in1_rdy = can_accept & grant1. At most one rdy is high in any cycle.
- sel = grant1. When there is no grant, sel holds its last registered value; it never glitches to the losing requester.
- out_msg is sourced through the 2:1 mux: sel ? in1_msg : in0_msg.
- On a granted transfer:
  - out_msg <= muxed message, out_val <= 1.
  - prio <= ~winner, so the loser is favoured next.
  - grant_count <= grant_count + 1 (mod 256).
- On out_val & out_rdy with no new grant: out_val <= 0. out_msg keeps its old value and is a don't-care.
- prio changes only on an accepted transfer. A single requester never moves prio away from an idle one unfairly: after an in0-only transfer, prio = 1.
- rdy outputs depend combinationally on val, out_val and out_rdy. No val depends on rdy, so there is no combinational loop.

## Timing
- Reset (reset = 0, async) forces:
  - out_val = 0, out_msg = 0, prio = 0, sel = 0, grant_count = 0.
  - in0_rdy = in1_rdy = 0 while reset is low.
- Normal operation resumes at the first rising edge after reset returns to 1.
- Latency is 1 cycle: a message accepted at edge N appears on out_msg with out_val = 1 after edge N.
- Throughput is 1 message/cycle while out_rdy = 1 and any input is valid.
- Backpressure: out_val = 1 with out_rdy = 0 forces both in*_rdy = 0. out_msg is held stable until drained.
- Simultaneous drain and refill in one cycle: out_val stays 1 and out_msg is replaced at that edge.
- Reset asserted mid-transfer: the pending message is discarded, no handshake completes, and prio returns to 0.
- grant_count wrap: 255 plus one transfer gives 0, with no flag.

## Test plan
- Reset: hold reset = 0 with in0_val = in1_val = 1 -> out_val = 0, in0_rdy = in1_rdy = 0, grant_count = 0; release reset -> first grant goes to in0.
- Single requester: in0_val = 1, in0_msg = 8'hA5, out_rdy = 1 -> in0_rdy = 1, sel = 0; next cycle out_msg = 8'hA5, out_val = 1, grant_count = 1.
- Round-robin: both valid continuously (in0_msg = 8'h11, in1_msg = 8'h22), out_rdy = 1 -> out_msg sequence 11, 22, 11, 22; sel alternates 0,1,0,1.
- Backpressure: FULL with out_msg = 8'h33, out_rdy = 0 for 3 cycles, both inputs valid -> in*_rdy = 0 and out_msg stays 8'h33; raise out_rdy -> same-cycle refill from the favoured requester.
- Async reset mid-stream: pull reset low between edges while out_val = 1 -> out_val drops to 0 immediately (no clock edge); prio = 0 afterward.
- Counter wrap and random: 256 transfers -> grant_count = 0. Then 20 random cycles of val/msg/out_rdy checked against a reference model: no lost or duplicated messages, no starvation beyond 1 cycle when both are valid.
